// File: rtl/id_ex_skid_reg_if.sv
// ID/EX skid register bus: decode-side input handshake and bundle,
// EX-side output handshake and bundle, plus the squash request.
interface id_ex_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] PC_in;
    logic [DATA_W-1:0] RD1_in;
    logic [DATA_W-1:0] RD2_in;
    logic [DATA_W-1:0] SE_in;
    logic [REG_W-1:0]  rs_in;
    logic [REG_W-1:0]  rt_in;
    logic [REG_W-1:0]  rd_in;
    logic [CTRL_W-1:0] control_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] PC_out;
    logic [DATA_W-1:0] RD1_out;
    logic [DATA_W-1:0] RD2_out;
    logic [DATA_W-1:0] SE_out;
    logic [REG_W-1:0]  rs_out;
    logic [REG_W-1:0]  rt_out;
    logic [REG_W-1:0]  rd_out;
    logic [CTRL_W-1:0] control_out;

    modport master (
        output in_valid, PC_in, RD1_in, RD2_in, SE_in,
        output rs_in, rt_in, rd_in, control_in, flush, out_ready,
        input  in_ready, out_valid, PC_out, RD1_out, RD2_out, SE_out,
        input  rs_out, rt_out, rd_out, control_out
    );

    modport slave (
        input  in_valid, PC_in, RD1_in, RD2_in, SE_in,
        input  rs_in, rt_in, rd_in, control_in, flush, out_ready,
        output in_ready, out_valid, PC_out, RD1_out, RD2_out, SE_out,
        output rs_out, rt_out, rd_out, control_out
    );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with valid/ready handshake and 2-entry skid.
// Define ID_EX_PERF_EN to add the saturating stall_cycles counter.
module id_ex_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    id_ex_skid_reg_if.slave    bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] se;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    bundle_t in_b;
    logic    in_fire;
    logic    out_fire;

    assign in_b = '{
        pc:   bus.PC_in,
        rd1:  bus.RD1_in,
        rd2:  bus.RD2_in,
        se:   bus.SE_in,
        rs:   bus.rs_in,
        rt:   bus.rt_in,
        rd:   bus.rd_in,
        ctrl: bus.control_in
    };

    // Ready depends on registered state only, so no out_ready->in_ready path.
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = bus.out_valid & bus.out_ready;

    assign bus.PC_out      = main_q.pc;
    assign bus.RD1_out     = main_q.rd1;
    assign bus.RD2_out     = main_q.rd2;
    assign bus.SE_out      = main_q.se;
    assign bus.rs_out      = main_q.rs;
    assign bus.rt_out      = main_q.rt;
    assign bus.rd_out      = main_q.rd;
    assign bus.control_out = bus.out_valid ? main_q.ctrl : '0;

    // Next-state and data steering; flush empties without touching data.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_b;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_b;
                    end else if (in_fire) begin
                        skid_d  = in_b;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and bundle registers; reset clears both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [15:0] stall_q;

    // Count cycles where EX holds off a valid bundle; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.out_valid && !bus.out_ready
                     && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed self-checking bench for id_ex_skid_reg.
// Each scenario task drives stimulus and checks outputs after the edge.
module tb_id_ex_skid_reg;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    id_ex_skid_reg_if #(.DATA_W(32), .REG_W(5), .CTRL_W(8)) bus ();

`ifdef ID_EX_PERF_EN
    logic [15:0] stall_cycles;
`endif

    id_ex_skid_reg #(.DATA_W(32), .REG_W(5), .CTRL_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ID_EX_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        bus.in_valid   = 1'b1;
        bus.PC_in      = pc;
        bus.RD1_in     = pc + 32'h100;
        bus.RD2_in     = pc + 32'h200;
        bus.SE_in      = pc + 32'h300;
        bus.rs_in      = 5'd1;
        bus.rt_in      = 5'd2;
        bus.rd_in      = 5'd3;
        bus.control_in = pc[7:0] ^ 8'h3C;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b exp 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %b exp 1", bus.in_ready);
        end
        checks++;
        if (bus.PC_out !== 32'h0 || bus.RD1_out !== 32'h0
            || bus.rd_out !== 5'h0) begin
            errors++;
            $display("FAIL rst_data got pc=%h rd1=%h rd=%h exp 0",
                     bus.PC_out, bus.RD1_out, bus.rd_out);
        end
        checks++;
        if (bus.control_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_ctrl got %h exp 00", bus.control_out);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [7:0]  ctl [3];
        pcs = '{32'h00, 32'h04, 32'h08};
        ctl = '{8'h3C, 8'h38, 8'h34};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(pcs[i]);
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.PC_out !== pcs[i]) begin
                errors++;
                $display("FAIL stream_pc%0d got v=%b pc=%h exp v=1 pc=%h",
                         i, bus.out_valid, bus.PC_out, pcs[i]);
            end
            checks++;
            if (bus.control_out !== ctl[i] || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ctl%0d got c=%h r=%b exp c=%h r=1",
                         i, bus.control_out, bus.in_ready, ctl[i]);
            end
        end
        checks++;
        if (bus.RD1_out !== 32'h108 || bus.SE_out !== 32'h308
            || bus.rt_out !== 5'd2) begin
            errors++;
            $display("FAIL stream_fields got rd1=%h se=%h rt=%h exp 108 308 2",
                     bus.RD1_out, bus.SE_out, bus.rt_out);
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.control_out !== 8'h00) begin
            errors++;
            $display("FAIL stream_drain got v=%b c=%h exp v=0 c=00",
                     bus.out_valid, bus.control_out);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        offer(32'h10);
        step();
        bus.out_ready = 1'b0;
        offer(32'h14);
        step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.PC_out !== 32'h10) begin
            errors++;
            $display("FAIL bp_full got r=%b pc=%h exp r=0 pc=10",
                     bus.in_ready, bus.PC_out);
        end
        offer(32'h18);
        step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.PC_out !== 32'h10
            || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got r=%b v=%b pc=%h exp r=0 v=1 pc=10",
                     bus.in_ready, bus.out_valid, bus.PC_out);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.PC_out !== 32'h14 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pc14 got pc=%h r=%b exp pc=14 r=1",
                     bus.PC_out, bus.in_ready);
        end
        step();
        checks++;
        if (bus.PC_out !== 32'h18 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_pc18 got pc=%h v=%b exp pc=18 v=1",
                     bus.PC_out, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_flush_full();
        bus.out_ready = 1'b0;
        offer(32'h20);
        step();
        offer(32'h24);
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill got r=%b exp 0", bus.in_ready);
        end
        bus.flush = 1'b1;
        offer(32'h40);
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.control_out !== 8'h00
            || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty got v=%b c=%h r=%b exp v=0 c=00 r=1",
                     bus.out_valid, bus.control_out, bus.in_ready);
        end
        checks++;
        if (bus.PC_out !== 32'h20) begin
            errors++;
            $display("FAIL flush_keep got pc=%h exp 20", bus.PC_out);
        end
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.PC_out === 32'h40) begin
            errors++;
            $display("FAIL flush_drop got v=%b pc=%h exp v=0 pc!=40",
                     bus.out_valid, bus.PC_out);
        end
    endtask

    task automatic test_bubble();
        bus.in_valid   = 1'b0;
        bus.control_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.control_out !== 8'h00) begin
                errors++;
                $display("FAIL bubble%0d got v=%b c=%h exp v=0 c=00",
                         i, bus.out_valid, bus.control_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        offer(32'h50);
        step();
        offer(32'h54);
        step();
        rst       = 1'b1;
        bus.flush = 1'b1;
        step();
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_hs got v=%b r=%b exp v=0 r=1",
                     bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.PC_out !== 32'h0 || bus.RD2_out !== 32'h0
            || bus.rs_out !== 5'h0 || bus.control_out !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_data got pc=%h rd2=%h rs=%h c=%h exp 0",
                     bus.PC_out, bus.RD2_out, bus.rs_out, bus.control_out);
        end
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        bus.out_ready = 1'b1;
        offer(32'h60);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL perf_count got %0d exp 5", stall_cycles);
        end
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++;
        if (stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL perf_flush got %0d exp 5", stall_cycles);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL perf_rst got %0d exp 0", stall_cycles);
        end
    endtask
`endif

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.PC_in      = '0;
        bus.RD1_in     = '0;
        bus.RD2_in     = '0;
        bus.SE_in      = '0;
        bus.rs_in      = '0;
        bus.rt_in      = '0;
        bus.rd_in      = '0;
        bus.control_in = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_bubble();
        test_reset_mid();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
